// File: rtl/dual_read_alu_pkg.sv
// Shared constants for the dual-read ALU engine: default widths,
// ALU op codes and the controller state encoding.
package dual_read_alu_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MAX  = 3'b101;
  localparam logic [2:0] OP_MIN  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/reg_mem_sp.sv
// Register-file memory with one write port and one synchronous read port.
// A read and a write to the same address on the same edge return the old
// contents. The array has no reset so its contents survive an engine reset.
module reg_mem_sp
  import dual_read_alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read on the same edge; non-blocking gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_read_alu_engine.sv
// Sequential two-operand compute core: reads A and B from a local register
// memory, applies an ALU op, reports result/carry/zero and optionally writes
// the result back.
//
// Handshake: start is sampled only while busy is low (IDLE). Once taken, all
// operation inputs are latched and busy stays high until done pulses for one
// cycle with result/carry/zero valid; those outputs hold until the next done.
// A start in the done cycle is accepted, since the controller is already idle.
module dual_read_alu_engine
  import dual_read_alu_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int WB_ENABLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [ADDR_W-1:0] adr2,
  input  logic [ADDR_W-1:0] adr_dst,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              wr_reject,
  output logic [2:0]        fsm_state
);

  state_t state, state_next;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] adr2_q;
  logic [ADDR_W-1:0] adr_dst_q;
  logic              wb_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  // Returns {carry_or_borrow, result}.
  function automatic logic [DATA_W:0] alu(input logic [2:0] f,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (f)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_MAX:  r = {1'b0, (a > b) ? a : b};
      OP_MIN:  r = {1'b0, (a < b) ? a : b};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  reg_mem_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: fixed walk through the read/execute sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RD_A;
      ST_RD_A: state_next = ST_RD_B;
      ST_RD_B: state_next = ST_EXEC;
      ST_EXEC: state_next = wb_q ? ST_WB : ST_IDLE;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output/control decode: busy flag and memory port steering.
  // In IDLE the read port follows adr1 directly so operand A is fetched on
  // the same edge that accepts start; afterwards it points at latched adr2.
  always_comb begin
    busy      = (state != ST_IDLE);
    mem_raddr = (state == ST_IDLE) ? adr1 : adr2_q;
    mem_we    = ((state == ST_IDLE) && wr_en) || (state == ST_WB);
    mem_waddr = (state == ST_WB) ? adr_dst_q : wr_addr;
    mem_wdata = (state == ST_WB) ? result : wr_data;
  end

  // Datapath registers: operand latches, ALU result/flags and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_ADD;
      adr2_q    <= '0;
      adr_dst_q <= '0;
      wb_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      done      <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      done      <= ((state == ST_EXEC) && !wb_q) || (state == ST_WB);
      wr_reject <= wr_en && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op;
            adr2_q    <= adr2;
            adr_dst_q <= adr_dst;
            wb_q      <= wb_en && (WB_ENABLE != 0);
          end
        end
        ST_RD_A: a_q <= mem_rdata;
        ST_RD_B: b_q <= mem_rdata;
        ST_EXEC: {carry, result} <= alu(op_q, a_q, b_q);
        default: ;
      endcase
    end
  end

  // Flag derived from the registered result so it tracks result exactly.
  assign zero      = (result == '0);
  assign fsm_state = state;

endmodule

// File: doc/dual_read_alu_engine.md
Name: dual_read_alu_engine

Overview:
- Parametrised successor to the two-address memory read/combine datapath.
- Holds a DEPTH x DATA_W single-port synchronous register memory, loaded through a host write port.
- On a start pulse it sequentially reads two addressed operands, applies a selectable ALU operation, and reports result, carry and zero flags.
- Optionally writes the result back to a destination address.
- Used as the compute core behind the lab top level.

Parameters:
DATA_W, 8, operand/result width in bits
ADDR_W, 3, address width; memory depth = 2**ADDR_W
WB_ENABLE, 1, 1 = writeback path built; 0 = wb_en ignored, WB state never entered

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
wr_en  input  1  host write strobe, accepted only in IDLE
wr_addr  input  ADDR_W  host write address
wr_data  input  DATA_W  host write data
start  input  1  operation request, sampled in IDLE only
op  input  3  ALU operation code
adr1  input  ADDR_W  operand A address
adr2  input  ADDR_W  operand B address
adr_dst  input  ADDR_W  writeback address
wb_en  input  1  request writeback of result
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when result is valid
result  output  DATA_W  last computed result, held until the next done
carry  output  1  carry (ADD) or borrow (SUB); 0 for other ops
zero  output  1  result == 0
wr_reject  output  1  one-cycle pulse when wr_en arrives while busy

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; busy, done, carry, wr_reject and result go to 0; zero goes to 1. Memory contents are not cleared.
- Reset mid-operation aborts the operation. No writeback occurs, and no done pulse follows.
- FSM states: IDLE -> RD_A -> RD_B -> EXEC -> (WB) -> IDLE.
- IDLE, start=1 at edge N:
  - latch op, adr1, adr2, adr_dst and wb_en (wb_en is ANDed with WB_ENABLE);
  - issue read of adr1;
  - go to RD_A.
- RD_A (edge N+1): capture A from memory output; issue read of adr2; go to RD_B.
- RD_B (edge N+2): capture B; go to EXEC.
- EXEC (edge N+3):
  - register result and flags;
  - if latched wb_en, go to WB, else IDLE with done=1 for the cycle following edge N+3.
- WB (edge N+4): write result to adr_dst; done=1 for the cycle following edge N+4; go to IDLE.
- Latency: done visible 4 cycles after start (5 with writeback).
- Inputs changing after start is accepted have no effect.
- start while busy is ignored and not queued.
- start and done in the same cycle: the new start is accepted (the FSM is in IDLE).
- Host writes:
  - in IDLE, wr_en writes mem[wr_addr] at the edge;
  - a read of the same address in the same cycle returns the OLD data (read-before-write);
  - wr_en while busy does not write and pulses wr_reject.
  - wr_en and start in the same IDLE cycle: both are accepted; the operand read sees the old data.
- adr1 == adr2 is legal; both operands take the same value.
- ALU ops (unsigned, DATA_W bits; extra bit → carry):
  - 000 ADD, A+B;
  - 001 SUB, A-B mod 2^DATA_W, carry = borrow (A<B);
  - 010 AND;
  - 011 OR;
  - 100 XOR;
  - 101 MAX(A,B);
  - 110 MIN(A,B);
  - 111 PASS A.
- zero is computed from the registered result.

Decomposition:
- Shared package dual_read_alu_pkg: op-code localparams (OP_ADD..OP_PASS), FSM state encoding, and the default width constants.
- One sub-module, reg_mem_sp: single-port synchronous read-before-write memory, parametrised by DATA_W/ADDR_W, no reset on the array.
- The ALU is a combinational function inside the engine.

Test Plan:
- Load mem[1]=0x10 and mem[2]=0x25; start ADD with adr1=1, adr2=2 → done 4 cycles later, result=0x35, carry=0, zero=0, busy high for 3 cycles.
- Load mem[3]=0xF0 and mem[5]=0x20: ADD 3,5 → result=0x10, carry=1. Then SUB 5,3 → result=0x30, carry=1. Then MAX → 0xF0.
- SUB 2,1 with wb_en=1, adr_dst=6 → done at 5 cycles, result=0x15. A following PASS with adr1=6 returns 0x15.
- Second start and a wr_en to addr 1 issued while busy → start ignored, wr_reject pulses once, mem[1] still 0x10, only one done pulse.
- XOR with adr1=adr2=2 → result=0x00, zero=1, carry=0.
- Drop rst low during RD_B → busy=0, result=0 immediately with no clock edge, no done pulse, no writeback. After release, a fresh ADD 1,2 still yields 0x35.
